cga_text_ctrl: RTL
==================

CGA_TEXT_CTRL -- requirements
Module: cga_text_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 25, meaning text rows per frame.
REQ-003 SHALL have parameter BLINK_LOG2, default 4, meaning the blink phase toggles every 2^BLINK_LOG2 frames.
REQ-004 Ports (name  direction  width  meaning):
- clk_i  in  1  pixel clock; one clock.
- rst_i  in  1  synchronous, active-high reset.
- de_i  in  1  display enable from the timing generator.
- hsync_i  in  1  horizontal sync.
- vsync_i  in  1  vertical sync, active-high.
- x_i  in  10  pixel column.
- y_i  in  10  pixel line.
- cursor_i  in  11  cursor cell index, row*COLS+col.
- tram_addr_o  out  11  text RAM cell address.
- tram_data_i  in  16  text RAM word: [15:8] attribute irgb-irgb (bg, fg), [7:0] character code; 1-cycle read latency.
- font_addr_o  out  12  font ROM address {char[7:0], glyph_row[3:0]}.
- font_data_i  in  8  glyph row, bit 7 leftmost; 1-cycle read latency.
- color_o  out  8  attribute for the colour stage, irgb-irgb.
- on_o  out  1  foreground pixel.
- de_o, hsync_o, vsync_o  out  1 each  inputs delayed to align with color_o/on_o.

Function
REQ-005 Cell geometry SHALL be 8x16 pixels: col = x_i[9:3], glyph_row = y_i[3:0], text row = y_i[9:4].
REQ-006 Stage 0 (cycle N) SHALL register tram_addr_o = row*COLS + col, computed without a generic multiplier (shift-add on the constant).
REQ-007 Stage 1 (N+1) SHALL register font_addr_o from tram_data_i[7:0] and the stage-0 glyph_row, and SHALL register the attribute.
REQ-008 Stage 2 (N+2) SHALL register on_o = font_data_i[7 - x[2:0]] using x delayed two cycles, together with color_o.
REQ-009 Latency from x_i/y_i/de_i/syncs to all outputs SHALL be exactly 3 cycles; de_o, hsync_o and vsync_o SHALL be delayed through matching registers.
REQ-010 If a pixel lies outside the text area (col >= COLS or row >= ROWS) or de_i=0, then on_o=0 and color_o=8'h00 for that pixel.
REQ-011 The cursor SHALL cover glyph rows 14-15 of cell cursor_i; there on_o is forced to 1 when the cursor is visible.
REQ-012 A cursor_i value >= ROWS*COLS SHALL show no cursor.
REQ-013 The frame counter SHALL increment on each vsync_i rising edge, wrap at 2^(BLINK_LOG2+1), and its MSB is the blink phase.
REQ-014 cursor_i changes SHALL take effect on the next pixel sampled; there is no frame-boundary latching.

Reset
REQ-015 While rst_i=1 at a clk_i edge: all outputs, pipeline registers and the frame counter SHALL clear to 0.
REQ-016 Reset asserted mid-line SHALL blank outputs for 3 cycles after release; the pipeline then resynchronizes with no further state.

Configuration
REQ-017 Macro CGA_TEXT_BLINK_EN, when defined:
- attribute bit 7 is blink enable;
- color_o[7] is forced to 0;
- cells with bit 7 set show on_o=0 during blink phase 0;
- the cursor is visible only in blink phase 1.
REQ-018 When CGA_TEXT_BLINK_EN is undefined:
- bit 7 passes through as background intensity;
- the cursor is always visible;
- the frame counter and vsync edge detector are omitted.

Structure
REQ-019 A shared package SHALL hold CELL_W=8, CELL_H=16, the attribute bit-field positions and the text-word field positions.
REQ-020 The blink/frame counter SHALL be one sub-module, cga_blink_gen, instantiated only under CGA_TEXT_BLINK_EN; the pipeline stays in the top.

Verification
REQ-021 x=17, y=35 -> tram_addr_o = 2*80+2 = 162 one cycle later; font_addr_o = {char, 4'd3} one cycle after that.
REQ-022 Word 16'h1E41, glyph row 8'h81, pixel x[2:0]=0 -> on_o=1, color_o=8'h1E three cycles after input; x[2:0]=3 -> on_o=0.
REQ-023 x=640 (col 80) or y=400 (row 25) with de_i=1 -> on_o=0, color_o=0; de_o still 1 (delayed).
REQ-024 cursor_i=0, glyph row 15 of cell 0 -> on_o=1 with blank glyph; cursor_i=2000 -> no cursor.
REQ-025 With CGA_TEXT_BLINK_EN: attribute 8'h9F toggles on_o between glyph and 0 every 16 frames; without it, color_o=8'h9F constant.
REQ-026 rst_i pulsed mid-line -> outputs 0 during reset and for 3 cycles after; correct pixels from cycle 4.

Source files
------------

// File: rtl/cga_text_ctrl_pkg.sv
// Shared constants for the CGA text-mode controller: cell geometry, attribute
// bit positions and the layout of a text RAM word.
package cga_text_ctrl_pkg;

    localparam int CELL_W      = 8;
    localparam int CELL_H      = 16;
    localparam int CELL_W_LOG2 = 3;
    localparam int CELL_H_LOG2 = 4;

    // Attribute byte is irgb (background) : irgb (foreground)
    localparam int ATTR_W         = 8;
    localparam int ATTR_FG_LSB    = 0;
    localparam int ATTR_BG_LSB    = 4;
    localparam int ATTR_BLINK_BIT = 7;

    localparam int CHAR_W        = 8;
    localparam int WORD_CHAR_LSB = 0;
    localparam int WORD_ATTR_LSB = 8;

    // Underline-style cursor occupies the bottom two glyph rows
    localparam logic [CELL_H_LOG2-1:0] CURSOR_ROW_FIRST = 4'd14;

    typedef struct packed {
        logic [ATTR_W-1:0] attr;
        logic [CHAR_W-1:0] code;
    } text_word_t;

endpackage

// File: rtl/cga_text_ctrl_blink_gen.sv
// Frame counter clocked by vsync rising edges; its MSB is the blink phase
// (toggles every 2^BLINK_LOG2 frames).
module cga_blink_gen #(
    parameter int BLINK_LOG2 = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    output logic phase_o
);

    logic                  vsync_prev_reg;
    logic [BLINK_LOG2:0]   frame_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_prev_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            vsync_prev_reg <= vsync_i;
            if (vsync_i && !vsync_prev_reg)
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign phase_o = frame_cnt_reg[BLINK_LOG2];

endmodule

// File: rtl/cga_text_ctrl.sv
// Three-stage CGA text-mode pixel pipeline: cell address -> font address ->
// pixel/attribute. Define CGA_TEXT_BLINK_EN to enable attribute blink and cursor blink.
module cga_text_ctrl
    import cga_text_ctrl_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int BLINK_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        de_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [10:0] cursor_i,
    output logic [10:0] tram_addr_o,
    input  logic [15:0] tram_data_i,
    output logic [11:0] font_addr_o,
    input  logic [7:0]  font_data_i,
    output logic [7:0]  color_o,
    output logic        on_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    localparam int IDX_W    = 13;  // holds 63*COLS + 127 for any COLS < 128
    localparam int MUL_BITS = 7;
    localparam logic [MUL_BITS-1:0] COLS_V  = MUL_BITS'(COLS);
    localparam logic [IDX_W-1:0]    COLS_W  = IDX_W'(COLS);
    localparam logic [IDX_W-1:0]    ROWS_W  = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0]    CELLS_W = IDX_W'(ROWS * COLS);

    logic [6:0]             col;
    logic [5:0]             row;
    logic [CELL_H_LOG2-1:0] glyph_row;
    logic [CELL_W_LOG2-1:0] x_lo;
    logic [IDX_W-1:0]       row_ext;
    logic [IDX_W-1:0]       pp [MUL_BITS];
    logic [IDX_W-1:0]       cell_idx;
    logic                   in_area;
    logic                   cursor_hit;

    assign col       = x_i[9:CELL_W_LOG2];
    assign x_lo      = x_i[CELL_W_LOG2-1:0];
    assign row       = y_i[9:CELL_H_LOG2];
    assign glyph_row = y_i[CELL_H_LOG2-1:0];
    assign row_ext   = IDX_W'(row);

    // row*COLS as a sum of shifted copies of row, one per set bit of COLS
    generate
        for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_mul
            assign pp[gi] = COLS_V[gi] ? (row_ext << gi) : '0;
        end
    endgenerate

    always_comb begin
        cell_idx = IDX_W'(col);
        for (int i = 0; i < MUL_BITS; i++)
            cell_idx = cell_idx + pp[i];
    end

    assign in_area    = de_i && (IDX_W'(col) < COLS_W) && (IDX_W'(row) < ROWS_W);
    assign cursor_hit = ({2'b00, cursor_i} == cell_idx) && ({2'b00, cursor_i} < CELLS_W)
                        && (glyph_row >= CURSOR_ROW_FIRST);

    // Pipeline state
    logic                   valid_s0_reg, valid_s1_reg;
    logic                   cursor_s0_reg, cursor_s1_reg;
    logic [CELL_W_LOG2-1:0] x_lo_s0_reg, x_lo_s1_reg;
    logic [CELL_H_LOG2-1:0] glyph_row_s0_reg;
    logic [ATTR_W-1:0]      attr_s1_reg;
    logic [2:0]             de_pipe_reg, hsync_pipe_reg, vsync_pipe_reg;

    text_word_t             word;
    logic                   pixel;
    logic                   blink_off;
    logic                   cursor_vis;
    logic [ATTR_W-1:0]      attr_shown;

    assign word  = text_word_t'(tram_data_i);
    assign pixel = font_data_i[3'd7 - x_lo_s1_reg];

`ifdef CGA_TEXT_BLINK_EN
    logic blink_phase;

    cga_blink_gen #(
        .BLINK_LOG2 (BLINK_LOG2)
    ) u_blink_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .vsync_i (vsync_i),
        .phase_o (blink_phase)
    );

    assign blink_off  = attr_s1_reg[ATTR_BLINK_BIT] & ~blink_phase;
    assign cursor_vis = blink_phase;
    assign attr_shown = {1'b0, attr_s1_reg[ATTR_W-2:0]};
`else
    assign blink_off  = 1'b0;
    assign cursor_vis = 1'b1;
    assign attr_shown = attr_s1_reg;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tram_addr_o      <= '0;
            valid_s0_reg     <= 1'b0;
            cursor_s0_reg    <= 1'b0;
            x_lo_s0_reg      <= '0;
            glyph_row_s0_reg <= '0;
            font_addr_o      <= '0;
            attr_s1_reg      <= '0;
            valid_s1_reg     <= 1'b0;
            cursor_s1_reg    <= 1'b0;
            x_lo_s1_reg      <= '0;
            on_o             <= 1'b0;
            color_o          <= '0;
            de_pipe_reg      <= '0;
            hsync_pipe_reg   <= '0;
            vsync_pipe_reg   <= '0;
        end else begin
            // Stage 0: cell address and per-pixel qualifiers
            tram_addr_o      <= cell_idx[10:0];
            valid_s0_reg     <= in_area;
            cursor_s0_reg    <= cursor_hit;
            x_lo_s0_reg      <= x_lo;
            glyph_row_s0_reg <= glyph_row;
            // Stage 1: text word arrives, look up the glyph row
            font_addr_o      <= {word.code, glyph_row_s0_reg};
            attr_s1_reg      <= word.attr;
            valid_s1_reg     <= valid_s0_reg;
            cursor_s1_reg    <= cursor_s0_reg;
            x_lo_s1_reg      <= x_lo_s0_reg;
            // Stage 2: select the pixel bit; blank everything outside the text area
            on_o             <= valid_s1_reg && ((pixel && !blink_off) || (cursor_s1_reg && cursor_vis));
            color_o          <= valid_s1_reg ? attr_shown : '0;
            de_pipe_reg      <= {de_pipe_reg[1:0], de_i};
            hsync_pipe_reg   <= {hsync_pipe_reg[1:0], hsync_i};
            vsync_pipe_reg   <= {vsync_pipe_reg[1:0], vsync_i};
        end
    end

    assign de_o    = de_pipe_reg[2];
    assign hsync_o = hsync_pipe_reg[2];
    assign vsync_o = vsync_pipe_reg[2];

endmodule
